// File: rtl/imem_loader_pkg.sv
// mips_pkg: constants and loader state encoding shared by the instruction
// memory loader, its interface and the testbench.
//   DATA_W   : instruction word width of the core ISA
//   LOAD_HDR : start-of-image marker byte
//   load_state_t : loader FSM states
package mips_pkg;

  localparam int DATA_W = 17;
  localparam logic [7:0] LOAD_HDR = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    B0,
    B1,
    B2,
    CSUM,
    RUN,
    ERROR
  } load_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream load channel plus the core fetch port.
//   rx_valid/rx_data/rx_ready : loader byte stream (valid/ready handshake)
//   pc/instr                  : core program counter and fetched instruction
// master drives the stream and pc; slave is the loader/memory.
interface imem_loader_if;

  logic                          rx_valid;
  logic [7:0]                    rx_data;
  logic                          rx_ready;
  logic [mips_pkg::DATA_W-1:0]   pc;
  logic [mips_pkg::DATA_W-1:0]   instr;

  modport master (
    output rx_valid, rx_data, pc,
    input  rx_ready, instr
  );

  modport slave (
    input  rx_valid, rx_data, pc,
    output rx_ready, instr
  );

endinterface

// File: rtl/imem_ram.sv
// imem_ram: instruction RAM, 2**ADDR_W words of DATA_W bits.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : asynchronous read address
//   rdata : asynchronous read data
// Contents are never cleared.
module imem_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 17
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// imem_loader: instruction memory for the single-cycle core, filled from a
// byte stream. Image format: A5, N (0 means 2**ADDR_W), then N words as
// three bytes each (bits 7:0, 15:8, then bit 16 in bit0 of the third byte).
// The core is held in reset until a complete, well-formed image is loaded.
// Optional build macro CHECKSUM_EN: one trailing byte equal to the XOR of
// all payload bytes must follow the last word, otherwise the load fails.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   bus         : slave side of imem_loader_if (byte stream + fetch port)
//   core_reset  : registered reset to the core (high unless running)
//   load_done   : registered, image loaded and core running
//   load_error  : last load attempt was malformed
//   word_count  : words written in the current/last load (saturating)
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = mips_pkg::DATA_W
) (
  input  logic            clk,
  input  logic            reset,
  imem_loader_if.slave    bus,
  output logic            core_reset,
  output logic            load_done,
  output logic            load_error,
  output logic [ADDR_W:0] word_count
);
  import mips_pkg::*;

  localparam logic [ADDR_W:0] WC_MAX = (ADDR_W+1)'(2**ADDR_W);

  load_state_t       state_q, state_d;
  logic              rx_ready_q;
  logic              take;
  logic              cnt_load;
  logic              wr_en;
  logic              is_last;
  logic [ADDR_W:0]   n_total_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [7:0]        b0_q, b1_q;
  logic [DATA_W-1:0] rdata;
`ifdef CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  assign bus.rx_ready = rx_ready_q;
  assign take    = bus.rx_valid && rx_ready_q;
  assign is_last = (word_count + 1'b1) == n_total_q;

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    wr_en    = 1'b0;
    if (take) begin
      case (state_q)
        IDLE, RUN, ERROR: if (bus.rx_data == LOAD_HDR) state_d = COUNT;
        COUNT: begin
          cnt_load = 1'b1;
          state_d  = B0;
        end
        B0: state_d = B1;
        B1: state_d = B2;
        B2: begin
          if (bus.rx_data[7:1] != 7'd0) begin
            state_d = ERROR;
          end else begin
            wr_en = 1'b1;
`ifdef CHECKSUM_EN
            state_d = is_last ? CSUM : B0;
`else
            state_d = is_last ? RUN : B0;
`endif
          end
        end
`ifdef CHECKSUM_EN
        CSUM: state_d = (bus.rx_data == csum_q) ? RUN : ERROR;
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  // Control: state, handshake, status and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rx_ready_q <= 1'b0;
      core_reset <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      word_count <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      rx_ready_q <= 1'b1;
      // Status follows the state one cycle later, so the core leaves reset
      // only after instr is already valid for a full cycle.
      core_reset <= (state_q != RUN);
      load_done  <= (state_q == RUN);
      if (cnt_load) begin
        word_count <= '0;
        wr_ptr_q   <= '0;
        load_error <= 1'b0;
      end else begin
        if (state_q == ERROR) load_error <= 1'b1;
        if (wr_en) begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
          if (word_count != WC_MAX) word_count <= word_count + 1'b1;
        end
      end
    end
  end

  // Data: byte latches, word total and running checksum (not reset)
  always_ff @(posedge clk) begin
    if (cnt_load) begin
      n_total_q <= (bus.rx_data == 8'd0) ? WC_MAX : (ADDR_W+1)'(bus.rx_data);
    end
    if (take && state_q == B0) b0_q <= bus.rx_data;
    if (take && state_q == B1) b1_q <= bus.rx_data;
`ifdef CHECKSUM_EN
    if (cnt_load) begin
      csum_q <= 8'd0;
    end else if (take && (state_q == B0 || state_q == B1 || state_q == B2)) begin
      csum_q <= csum_q ^ bus.rx_data;
    end
`endif
  end

  imem_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata ({bus.rx_data[0], b1_q, b0_q}),
    .raddr (bus.pc[ADDR_W-1:0]),
    .rdata (rdata)
  );

  // Out-of-range fetches and fetches outside RUN return a zero word.
  assign bus.instr = (state_q == RUN && bus.pc[DATA_W-1:ADDR_W] == '0) ? rdata : '0;

endmodule
